// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
// Round-robin multi-approach traffic-light controller. Each approach gets
// GREEN -> YELLOW -> ALL_RED in turn, with phase lengths counted in 1 s ticks.
// Pedestrian requests are latched per approach and served as a walk lamp
// during that approach's next green. A pending pedestrian on another
// approach may shorten the current green when priority_en is high.
// Optional feature: define EMERGENCY_PREEMPT_EN to add emergency preemption
// (ports emergency and emergency_dir).
module traffic_intersection_ctrl #(
    parameter int NUM_DIRS        = 4,
    parameter int GREEN_TICKS     = 10,
    parameter int MIN_GREEN_TICKS = 3,
    parameter int YELLOW_TICKS    = 2,
    parameter int ALLRED_TICKS    = 1,
    parameter int CNT_W           = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_1s,
    input  logic [NUM_DIRS-1:0]         ped_req,
    input  logic                        priority_en,
    output logic [NUM_DIRS-1:0]         green,
    output logic [NUM_DIRS-1:0]         yellow,
    output logic [NUM_DIRS-1:0]         red,
    output logic [NUM_DIRS-1:0]         walk,
    output logic [$clog2(NUM_DIRS)-1:0] active_dir,
    output logic                        phase_start
`ifdef EMERGENCY_PREEMPT_EN
    ,
    input  logic                        emergency,
    input  logic [$clog2(NUM_DIRS)-1:0] emergency_dir
`endif
);

    localparam int DIR_W = $clog2(NUM_DIRS);

    localparam logic [1:0] S_GREEN  = 2'd0;
    localparam logic [1:0] S_YELLOW = 2'd1;
    localparam logic [1:0] S_ALLRED = 2'd2;

    localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIRS - 1);

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic [DIR_W-1:0]    next_dir;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_DIRS-1:0] ped_pend;
    logic                walk_grant;
    logic                hold_cnt;
    logic [NUM_DIRS-1:0] active_mask;
    logic [NUM_DIRS-1:0] next_mask;
    logic [NUM_DIRS-1:0] pend_seen;
    logic                green_done;
    logic                yellow_done;
    logic                allred_done;
    logic                early_cut;
    logic                state_change;
    logic                enter_green;

    assign active_mask = NUM_DIRS'(1) << active_dir;
    assign next_mask   = NUM_DIRS'(1) << next_dir;
    assign pend_seen   = ped_pend | ped_req;

    assign green_done  = tick_1s && (cnt == CNT_W'(GREEN_TICKS - 1));
    assign yellow_done = tick_1s && (cnt == CNT_W'(YELLOW_TICKS - 1));
    assign allred_done = tick_1s && (cnt == CNT_W'(ALLRED_TICKS - 1));

    // The cut looks at requests already latched, never at this cycle's ped_req,
    // and ignores a request for the approach that already has green.
    assign early_cut   = tick_1s && priority_en
                         && (cnt >= CNT_W'(MIN_GREEN_TICKS - 1))
                         && (|(ped_pend & ~active_mask));

    assign state_change = (next_state != state);
    assign enter_green  = (state == S_ALLRED) && (next_state == S_GREEN);

    // Lamps and walk are decoded purely from registered state.
    assign green  = (state == S_GREEN)  ? active_mask : '0;
    assign yellow = (state == S_YELLOW) ? active_mask : '0;
    assign red    = ~(green | yellow);
    assign walk   = ((state == S_GREEN) && walk_grant) ? active_mask : '0;

    // Next phase and next owning approach.
    always_comb begin
        next_state = state;
        next_dir   = active_dir;
        hold_cnt   = 1'b0;
        case (state)
            S_GREEN: begin
                if (green_done || early_cut) begin
                    next_state = S_YELLOW;
                end
`ifdef EMERGENCY_PREEMPT_EN
                if (emergency) begin
                    if (active_dir == emergency_dir) begin
                        next_state = S_GREEN;
                        hold_cnt   = 1'b1;
                    end else begin
                        next_state = S_YELLOW;
                    end
                end
`endif
            end
            S_YELLOW: begin
                if (yellow_done) begin
                    next_state = S_YELLOW + 2'd1;
                end
            end
            S_ALLRED: begin
                if (allred_done) begin
                    next_state = S_GREEN;
                    next_dir   = (active_dir == LAST_DIR) ? '0 : active_dir + 1'b1;
`ifdef EMERGENCY_PREEMPT_EN
                    if (emergency) begin
                        next_dir = emergency_dir;
                    end
`endif
                end
            end
            default: begin
                next_state = S_GREEN;
            end
        endcase
    end

    // Phase register, owning approach, tick counter and phase_start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_GREEN;
            active_dir  <= '0;
            cnt         <= '0;
            phase_start <= 1'b0;
        end else begin
            state       <= next_state;
            active_dir  <= next_dir;
            phase_start <= state_change;
            if (state_change) begin
                cnt <= '0;
            end else if (tick_1s && !hold_cnt) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Pedestrian latching; a request arriving on the green-entry edge is served at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend   <= '0;
            walk_grant <= 1'b0;
        end else if (enter_green) begin
            ped_pend   <= pend_seen & ~next_mask;
            walk_grant <= |(pend_seen & next_mask);
        end else begin
            ped_pend <= pend_seen;
            if (state_change) begin
                walk_grant <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl
// Randomised bench for traffic_intersection_ctrl. A phase-level reference
// model predicts every phase change; predictions go into a queue and a
// negedge monitor pops one whenever the DUT pulses phase_start.
module tb_traffic_intersection_ctrl;

    localparam int N        = 4;
    localparam int GREEN_T  = 10;
    localparam int MIN_G    = 3;
    localparam int YELLOW_T = 2;
    localparam int ALLRED_T = 1;
    localparam int DW       = $clog2(N);

    typedef struct {
        int           cycle;
        logic [N-1:0] g;
        logic [N-1:0] y;
        logic [N-1:0] r;
        logic [N-1:0] w;
        int           dir;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_1s = 1'b0;
    logic [N-1:0]  ped_req = '0;
    logic          priority_en = 1'b0;
    logic [N-1:0]  green;
    logic [N-1:0]  yellow;
    logic [N-1:0]  red;
    logic [N-1:0]  walk;
    logic [DW-1:0] active_dir;
    logic          phase_start;
`ifdef EMERGENCY_PREEMPT_EN
    logic          emergency = 1'b0;
    logic [DW-1:0] emergency_dir = '0;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   sb_on = 1'b0;
    exp_t exp_q[$];

    // Reference model state: phase 0=green 1=yellow 2=all-red, ticks elapsed in phase.
    int           m_phase;
    int           m_dir;
    int           m_elapsed;
    logic [N-1:0] m_pend;
    logic         m_walk;
    int           dur[3] = '{GREEN_T, YELLOW_T, ALLRED_T};

    traffic_intersection_ctrl #(
        .NUM_DIRS(N), .GREEN_TICKS(GREEN_T), .MIN_GREEN_TICKS(MIN_G),
        .YELLOW_TICKS(YELLOW_T), .ALLRED_TICKS(ALLRED_T), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .tick_1s(tick_1s), .ped_req(ped_req),
        .priority_en(priority_en), .green(green), .yellow(yellow), .red(red),
        .walk(walk), .active_dir(active_dir), .phase_start(phase_start)
`ifdef EMERGENCY_PREEMPT_EN
        , .emergency(emergency), .emergency_dir(emergency_dir)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index, used to timestamp predictions.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic modelReset();
        m_phase   = 0;
        m_dir     = 0;
        m_elapsed = 0;
        m_pend    = '0;
        m_walk    = 1'b0;
    endtask

    task automatic pushExpected();
        exp_t e;
        logic [N-1:0] own;
        own     = '0;
        own[m_dir] = 1'b1;
        e.cycle = cyc + 1;
        e.g     = (m_phase == 0) ? own : '0;
        e.y     = (m_phase == 1) ? own : '0;
        e.r     = ~(e.g | e.y);
        e.w     = (m_phase == 0 && m_walk) ? own : '0;
        e.dir   = m_dir;
        exp_q.push_back(e);
    endtask

    // Predicts the effect of the coming clock edge given this cycle's inputs.
    task automatic modelStep(input logic t, input logic [N-1:0] req, input logic pri);
        bit           advance;
        logic [N-1:0] others;
        logic [N-1:0] seen;
        advance = 1'b0;
        others  = m_pend;
        others[m_dir] = 1'b0;
        if (t) begin
            if (m_elapsed + 1 == dur[m_phase]) advance = 1'b1;
            else if (m_phase == 0 && pri && m_elapsed + 1 >= MIN_G && others != '0) advance = 1'b1;
        end
        seen = m_pend | req;
        if (advance) begin
            m_phase   = (m_phase + 1) % 3;
            m_elapsed = 0;
            m_walk    = 1'b0;
            if (m_phase == 0) begin
                m_dir  = (m_dir + 1) % N;
                m_walk = seen[m_dir];
                seen[m_dir] = 1'b0;
            end
            pushExpected();
        end else if (t) begin
            m_elapsed++;
        end
        m_pend = seen;
    endtask

    task automatic applyStimulus(input logic t, input logic [N-1:0] req, input logic pri);
        tick_1s     = t;
        ped_req     = req;
        priority_en = pri;
        modelStep(t, req, pri);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_green"}, 32'(green), 32'(4'b0001));
        checkOutput({tag, "_yellow"}, 32'(yellow), 32'd0);
        checkOutput({tag, "_red"}, 32'(red), 32'(4'b1110));
        checkOutput({tag, "_walk"}, 32'(walk), 32'd0);
        checkOutput({tag, "_dir"}, 32'(active_dir), 32'd0);
        checkOutput({tag, "_phase_start"}, 32'(phase_start), 32'd0);
    endtask

    // Scoreboard monitor: pops a prediction on each phase_start, flags late or missing ones.
    always @(negedge clk) begin
        if (sb_on) begin
            checkOutput("lamp_cover", 32'(green | yellow | red), 32'(4'b1111));
            checkOutput("lamp_overlap", 32'((green & yellow) | (green & red) | (yellow & red)), 32'd0);
            if (phase_start) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_phase_start", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("phase_cycle", 32'(cyc), 32'(e.cycle));
                    checkOutput("phase_green", 32'(green), 32'(e.g));
                    checkOutput("phase_yellow", 32'(yellow), 32'(e.y));
                    checkOutput("phase_red", 32'(red), 32'(e.r));
                    checkOutput("phase_walk", 32'(walk), 32'(e.w));
                    checkOutput("phase_dir", 32'(active_dir), 32'(e.dir));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cycle <= cyc) begin
                checkOutput("missed_phase_start", 32'(exp_q[0].cycle), 32'(cyc + 1000000));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int  step;
        bit  found;
        modelReset();
        #2;
        checkResetState("reset");
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset_held");
        rst   = 1'b0;
        sb_on = 1'b1;

        // Priority cut: request for dir1 at the first tick of dir0 green.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(i % 4 == 3, (i == 3) ? 4'b0010 : 4'b0000, 1'b1);
        end

        // Plain round-robin, one tick every 4 clocks, covering a full wrap.
        for (int i = 0; i < 4 * 60; i++) begin
            applyStimulus(i % 4 == 3, 4'b0000, 1'b0);
        end

        // Pedestrian for dir2 raised during dir0 green without priority.
        found = 1'b0;
        for (step = 0; step < 400 && !found; step++) begin
            if (m_phase == 0 && m_dir == 0) found = 1'b1;
            else applyStimulus(1'b1, 4'b0000, 1'b0);
        end
        checkOutput("wait_dir0_green", 32'(found), 32'd1);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 4 * 40; i++) begin
            applyStimulus(i % 4 == 3, 4'b0000, 1'b0);
        end

        // Request for dir0 on the very edge that enters dir0 green.
        found = 1'b0;
        for (step = 0; step < 400 && !found; step++) begin
            if (m_phase == 2 && m_dir == N - 1 && m_elapsed + 1 == ALLRED_T) begin
                applyStimulus(1'b1, 4'b0001, 1'b0);
                found = 1'b1;
            end else begin
                applyStimulus(1'b1, 4'b0000, 1'b0);
            end
        end
        checkOutput("wait_dir0_entry", 32'(found), 32'd1);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0);
        end

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 2) == 0,
                          ($urandom_range(0, 7) == 0) ? N'($urandom) : '0,
                          N'($urandom) != 0 ? 1'($urandom) : 1'b0);
        end

        // Asynchronous reset in the middle of dir2 yellow.
        found = 1'b0;
        for (step = 0; step < 600 && !found; step++) begin
            if (m_phase == 1 && m_dir == 2) found = 1'b1;
            else applyStimulus(1'b1, ($urandom_range(0, 5) == 0) ? N'($urandom) : '0, 1'b0);
        end
        checkOutput("wait_dir2_yellow", 32'(found), 32'd1);
        sb_on       = 1'b0;
        tick_1s     = 1'b0;
        ped_req     = '0;
        priority_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkResetState("async_reset");
        exp_q.delete();
        modelReset();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        sb_on = 1'b1;

        // Traffic after reset; requests raised before reset must have been discarded.
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 1) == 0,
                          ($urandom_range(0, 9) == 0) ? N'($urandom) : '0,
                          1'($urandom));
        end

        // Drain and confirm every prediction was matched.
        applyStimulus(1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
